// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: a small circular FIFO of {pc, instruction} pairs with branch/exception flush.
// Define IFID_DELAY_SLOT_EN to keep the branch-delay-slot instruction on a taken-branch flush.
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              inst_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     br,
  input  logic                     except,
  output logic [31:0]              pc_out,
  output logic [31:0]              inst_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;

  logic push;
  logic pop;
  logic flush_all;

  // Handshake is derived from registered occupancy only, so in_ready never depends on out_ready.
  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = occ;

  assign pc_out    = out_valid ? pc_mem[rd_ptr]   : 32'h0000_0000;
  assign inst_out  = out_valid ? inst_mem[rd_ptr] : NOP_WORD;

`ifdef IFID_DELAY_SLOT_EN
  logic        br_keep;
  logic        keep_valid;
  logic [31:0] keep_pc;
  logic [31:0] keep_inst;

  assign flush_all = except;
  assign br_keep   = br & ~except;

  // The delay-slot survivor is the oldest pair ID has not consumed this cycle.
  always_comb begin
    keep_valid = 1'b0;
    keep_pc    = 32'h0000_0000;
    keep_inst  = 32'h0000_0000;
    if (!pop && occ != '0) begin
      keep_valid = 1'b1;
      keep_pc    = pc_mem[rd_ptr];
      keep_inst  = inst_mem[rd_ptr];
    end else if (pop && occ >= CW'(2)) begin
      keep_valid = 1'b1;
      keep_pc    = pc_mem[rd_ptr + PW'(1)];
      keep_inst  = inst_mem[rd_ptr + PW'(1)];
    end else if (push) begin
      keep_valid = 1'b1;
      keep_pc    = pc_in;
      keep_inst  = inst_in;
    end
  end
`else
  assign flush_all = except | br;
`endif

  // Pointer and occupancy bookkeeping; a flush overrides the normal push/pop update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
`ifdef IFID_DELAY_SLOT_EN
    end else if (br_keep) begin
      rd_ptr <= '0;
      if (keep_valid) begin
        wr_ptr <= PW'(1);
        occ    <= CW'(1);
      end else begin
        wr_ptr <= '0;
        occ    <= '0;
      end
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset; the output mux hides stale contents while the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_all) begin
`ifdef IFID_DELAY_SLOT_EN
      if (br_keep) begin
        if (keep_valid) begin
          pc_mem[0]   <= keep_pc;
          inst_mem[0] <= keep_inst;
        end
      end else if (push) begin
        pc_mem[wr_ptr]   <= pc_in;
        inst_mem[wr_ptr] <= inst_in;
      end
`else
      if (push) begin
        pc_mem[wr_ptr]   <= pc_in;
        inst_mem[wr_ptr] <= inst_in;
      end
`endif
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus randomized traffic against a queue model.
// Honours IFID_DELAY_SLOT_EN the same way the design does.
module tb_if_id_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        br = 1'b0;
  logic        except = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_in(inst_in),
    .in_valid(in_valid), .in_ready(in_ready), .br(br), .except(except),
    .pc_out(pc_out), .inst_out(inst_out), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  pair_t mq[$];
  int tests_run = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every visible output with what the queue model says the buffer holds.
  task automatic check_output();
    int n;
    n = mq.size();
    check("count",     32'(count),     32'(n));
    check("out_valid", 32'(out_valid), 32'(n != 0));
    check("in_ready",  32'(in_ready),  32'(n != DEPTH));
    check("pc_out",    pc_out,         (n != 0) ? mq[0].pc   : 32'h0);
    check("inst_out",  inst_out,       (n != 0) ? mq[0].inst : NOP);
  endtask

  task automatic apply_stimulus(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                                input logic ordy, input logic b, input logic ex);
    in_valid  = iv;
    pc_in     = pc;
    inst_in   = inst;
    out_ready = ordy;
    br        = b;
    except    = ex;
  endtask

  // Advance one clock: the model applies the FIFO/flush rules to the inputs present at the edge.
  task automatic tick();
    pair_t nq[$];
    pair_t k;
    logic  push, pop;
    nq   = mq;
    push = in_valid && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && out_ready;
    if (except) begin
      nq.delete();
    end else if (br) begin
`ifdef IFID_DELAY_SLOT_EN
      if (pop)  void'(nq.pop_front());
      if (push) nq.push_back('{pc: pc_in, inst: inst_in});
      if (nq.size() > 0) begin
        k = nq[0];
        nq.delete();
        nq.push_back(k);
      end
`else
      nq.delete();
`endif
    end else begin
      if (pop)  void'(nq.pop_front());
      if (push) nq.push_back('{pc: pc_in, inst: inst_in});
    end
    @(posedge clk);
    mq = nq;
    #1;
    check_output();
  endtask

  initial begin
    // Pushes offered during reset must be ignored.
    apply_stimulus(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("reset_count",     32'(count),     32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_pc_out",    pc_out,         32'h0);
    check("reset_inst_out",  inst_out,       32'h0);
    check("reset_in_ready",  32'(in_ready),  32'd1);

    // Two pairs streamed straight through with ID always ready.
    apply_stimulus(1'b1, 32'h0000_0000, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    tick();
    check("stream_valid1", 32'(out_valid), 32'd1);
    check("stream_inst1",  inst_out,       32'h2008_0005);
    apply_stimulus(1'b1, 32'h0000_0004, 32'h2009_0003, 1'b1, 1'b0, 1'b0);
    tick();
    check("stream_pc2",    pc_out,         32'h0000_0004);
    check("stream_inst2",  inst_out,       32'h2009_0003);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stream_drained", 32'(count), 32'd0);

    // Back-pressure: three pairs offered while ID stalls, then released across wrap.
    apply_stimulus(1'b1, 32'h100, 32'hA000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h104, 32'hA000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    check("stall_full_count", 32'(count),    32'd2);
    check("stall_in_ready",   32'(in_ready), 32'd0);
    apply_stimulus(1'b1, 32'h108, 32'hA000_0002, 1'b0, 1'b0, 1'b0);
    tick();
    check("stall_held_count", 32'(count), 32'd2);
    check("stall_head_pc",    pc_out,     32'h100);
    apply_stimulus(1'b1, 32'h108, 32'hA000_0002, 1'b1, 1'b0, 1'b0);
    tick();
    check("full_pop_count", 32'(count), 32'd1);
    check("full_pop_head",  pc_out,     32'h104);
    tick();
    check("wrap_count", 32'(count), 32'd1);
    check("wrap_head",  inst_out,   32'hA000_0002);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("wrap_drained", 32'(count), 32'd0);

    // Exception and branch together with a push pending: everything goes.
    apply_stimulus(1'b1, 32'h200, 32'hB000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h204, 32'hB000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h208, 32'hB000_0002, 1'b0, 1'b1, 1'b1);
    tick();
    check("flush_count",    32'(count),     32'd0);
    check("flush_valid",    32'(out_valid), 32'd0);
    check("flush_inst",     inst_out,       32'h0000_0000);
    check("flush_in_ready", 32'(in_ready),  32'd1);

    // Taken branch with head consumed: the delay-slot entry survives only with the feature on.
    apply_stimulus(1'b1, 32'h10, 32'hC000_000A, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h14, 32'hC000_000B, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
`ifdef IFID_DELAY_SLOT_EN
    check("br_slot_count", 32'(count), 32'd1);
    check("br_slot_pc",    pc_out,     32'h14);
    check("br_slot_inst",  inst_out,   32'hC000_000B);
`else
    check("br_slot_count", 32'(count), 32'd0);
    check("br_slot_pc",    pc_out,     32'h0);
    check("br_slot_inst",  inst_out,   32'h0);
`endif
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();

    // Asynchronous reset between edges with the buffer full.
    apply_stimulus(1'b1, 32'h300, 32'hD000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h304, 32'hD000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", 32'(count),     32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_inst",  inst_out,       32'h0);
    mq.delete();
    #2;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 32'h400, 32'hE000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("post_reset_pc",   pc_out,   32'h400);
    check("post_reset_inst", inst_out, 32'hE000_0000);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();

    // Randomized traffic with occasional redirects and exceptions.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, $urandom, $urandom,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 31) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
